// File: rtl/hh_step_sequencer_if.sv
// Shared-multiplier bus of the HH step sequencer.
// The sequencer issues operands; the multiplier returns a registered product.
interface hh_step_sequencer_if;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;

  modport master (
    output mul_a,
    output mul_b,
    output mul_en,
    input  mul_p
  );

  modport slave (
    input  mul_a,
    input  mul_b,
    input  mul_en,
    output mul_p
  );
endinterface

// File: rtl/hh_step_sequencer.sv
// Hodgkin-Huxley style membrane step: three conductance terms through
// one external multiplier, then Euler update of the Q8.8 potential.
module hh_step_sequencer #(
  parameter int E_L      = -17920,
  parameter int E_NA     = 12800,
  parameter int E_K      = -19712,
  parameter int DT_SHIFT = 4,
  parameter int V_TH     = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [15:0]                 g_l,
  input  logic [15:0]                 g_na,
  input  logic [15:0]                 g_k,
  input  logic [15:0]                 i_ext,
  hh_step_sequencer_if.master         mul,
  output logic [15:0]                 v_out,
  output logic                        busy,
  output logic                        done,
  output logic                        spike,
  output logic [15:0]                 step_cnt
);

  localparam logic signed [15:0] L_EL  = 16'(E_L);
  localparam logic signed [15:0] L_ENA = 16'(E_NA);
  localparam logic signed [15:0] L_EK  = 16'(E_K);
  localparam logic signed [15:0] L_VTH = 16'(V_TH);

  typedef enum logic [2:0] {
    IDLE,
    MUL_L,
    MUL_NA,
    MUL_K,
    DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [15:0] r_gl;
  logic signed [15:0] r_gna;
  logic signed [15:0] r_gk;
  logic signed [15:0] r_iext;
  logic signed [15:0] r_v;
  logic signed [25:0] r_acc;

  logic signed [31:0] w_psh;
  logic signed [31:0] w_itot;
  logic signed [31:0] w_dv;
  logic signed [31:0] w_vsum;
  logic signed [15:0] w_vnext;
  logic               w_spike;
  logic signed [15:0] w_bl;
  logic signed [15:0] w_bna;
  logic signed [15:0] w_bk;
  logic [15:0]        w_mul_a;
  logic [15:0]        w_mul_b;
  logic               w_mul_en;

  function automatic logic signed [31:0] sx(input logic signed [15:0] x);
    return {{16{x[15]}}, x};
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767)
      return 16'sh7FFF;
    else if (x < -32'sd32768)
      return 16'sh8000;
    else
      return 16'(x);
  endfunction

  assign w_bl  = sat16(sx(r_v) - sx(L_EL));
  assign w_bna = sat16(sx(r_v) - sx(L_ENA));
  assign w_bk  = sat16(sx(r_v) - sx(L_EK));

  // Product arrives as Q16.16; the running sum and its update share one adder.
  assign w_psh   = $signed(mul.mul_p) >>> 8;
  assign w_itot  = {{6{r_acc[25]}}, r_acc} + w_psh;
  assign w_dv    = (sx(r_iext) - w_itot) >>> DT_SHIFT;
  assign w_vsum  = sx(r_v) + w_dv;
  assign w_vnext = sat16(w_vsum);
  assign w_spike = (r_v < L_VTH) && (w_vnext >= L_VTH);

  always_comb begin
    w_next   = r_state;
    w_mul_en = 1'b0;
    w_mul_a  = '0;
    w_mul_b  = '0;
    unique case (r_state)
      IDLE: begin
        if (start)
          w_next = MUL_L;
      end
      MUL_L: begin
        w_next   = MUL_NA;
        w_mul_en = 1'b1;
        w_mul_a  = r_gl;
        w_mul_b  = w_bl;
      end
      MUL_NA: begin
        w_next   = MUL_K;
        w_mul_en = 1'b1;
        w_mul_a  = r_gna;
        w_mul_b  = w_bna;
      end
      MUL_K: begin
        w_next   = DRAIN;
        w_mul_en = 1'b1;
        w_mul_a  = r_gk;
        w_mul_b  = w_bk;
      end
      DRAIN: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign mul.mul_en = w_mul_en;
  assign mul.mul_a  = w_mul_a;
  assign mul.mul_b  = w_mul_b;
  assign busy       = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gl     <= '0;
      r_gna    <= '0;
      r_gk     <= '0;
      r_iext   <= '0;
      r_v      <= L_EL;
      r_acc    <= '0;
      v_out    <= L_EL;
      done     <= 1'b0;
      spike    <= 1'b0;
      step_cnt <= '0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      spike   <= 1'b0;
      if (r_state == IDLE && start) begin
        r_gl   <= g_l;
        r_gna  <= g_na;
        r_gk   <= g_k;
        r_iext <= i_ext;
        r_v    <= v_out;
        r_acc  <= '0;
      end
      if (r_state == MUL_NA || r_state == MUL_K)
        r_acc <= w_itot[25:0];
      if (r_state == DRAIN) begin
        v_out    <= w_vnext;
        done     <= 1'b1;
        spike    <= w_spike;
        step_cnt <= step_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_hh_step_sequencer.sv
// Scoreboard bench for hh_step_sequencer: default build (A) and a
// DT_SHIFT=0 build (B) driven with the same stimulus.
module tb_hh_step_sequencer;

  localparam longint EL  = -17920;
  localparam longint ENA = 12800;
  localparam longint EK  = -19712;

  typedef struct packed {
    logic [15:0] v;
    logic        spk;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] g_l = '0, g_na = '0, g_k = '0, i_ext = '0;

  logic [15:0] a_v, a_cnt, b_v, b_cnt;
  logic        a_busy, a_done, a_spk;
  logic        b_busy, b_done, b_spk;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  exp_t qa[$];
  exp_t qb[$];

  int          ph = 0;
  logic        m_done = 1'b0;
  longint      va = EL, vb = EL, lv = EL;
  longint      lgl = 0, lgna = 0, lgk = 0;
  logic [15:0] mcnt = '0;

  hh_step_sequencer_if ifa ();
  hh_step_sequencer_if ifb ();

  hh_step_sequencer u_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .g_l(g_l), .g_na(g_na), .g_k(g_k), .i_ext(i_ext),
    .mul(ifa),
    .v_out(a_v), .busy(a_busy), .done(a_done),
    .spike(a_spk), .step_cnt(a_cnt)
  );

  hh_step_sequencer #(.DT_SHIFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .g_l(g_l), .g_na(g_na), .g_k(g_k), .i_ext(i_ext),
    .mul(ifb),
    .v_out(b_v), .busy(b_busy), .done(b_done),
    .spike(b_spk), .step_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ifa.mul_p <= 32'($signed(ifa.mul_a) * $signed(ifa.mul_b));
    ifb.mul_p <= 32'($signed(ifb.mul_a) * $signed(ifb.mul_b));
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic longint s16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic longint vnext(input longint v, input longint g1,
                                   input longint g2, input longint g3,
                                   input longint ie, input int sh);
    longint it;
    it = ((g1 * s16(v - EL)) >>> 8) + ((g2 * s16(v - ENA)) >>> 8)
       + ((g3 * s16(v - EK)) >>> 8);
    return s16(v + ((ie - it) >>> sh));
  endfunction

  // Reference sequencer: phase 0 idle, 1..4 the busy cycles.
  always @(posedge clk or negedge rst_n) begin
    longint na, nb, gl, gna, gk, ie;
    logic [15:0] nc;
    if (!rst_n) begin
      ph     <= 0;
      m_done <= 1'b0;
      va     <= EL;
      vb     <= EL;
      mcnt   <= '0;
      qa.delete();
      qb.delete();
    end else begin
      m_done <= (ph == 4);
      if (ph == 0) begin
        if (start) begin
          gl  = longint'($signed(g_l));
          gna = longint'($signed(g_na));
          gk  = longint'($signed(g_k));
          ie  = longint'($signed(i_ext));
          na  = vnext(va, gl, gna, gk, ie, 4);
          nb  = vnext(vb, gl, gna, gk, ie, 0);
          nc  = mcnt + 16'd1;
          qa.push_back('{v: 16'(na), spk: (va < 0 && na >= 0), cnt: nc});
          qb.push_back('{v: 16'(nb), spk: (vb < 0 && nb >= 0), cnt: nc});
          lv   <= va;
          lgl  <= gl;
          lgna <= gna;
          lgk  <= gk;
          va   <= na;
          vb   <= nb;
          mcnt <= nc;
          ph   <= 1;
        end
      end else begin
        ph <= (ph == 4) ? 0 : ph + 1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic [15:0] ea, eb;
    if (chk_en) begin
      ea = '0;
      eb = '0;
      if (ph == 1) begin ea = 16'(lgl);  eb = 16'(s16(lv - EL));  end
      if (ph == 2) begin ea = 16'(lgna); eb = 16'(s16(lv - ENA)); end
      if (ph == 3) begin ea = 16'(lgk);  eb = 16'(s16(lv - EK));  end
      chk("busy_a", 32'(a_busy), 32'(ph != 0));
      chk("busy_b", 32'(b_busy), 32'(ph != 0));
      chk("mul_en_a", 32'(ifa.mul_en), 32'(ph inside {[1:3]}));
      chk("mul_a_a", 32'(ifa.mul_a), 32'(ea));
      chk("mul_b_a", 32'(ifa.mul_b), 32'(eb));
      chk("done_a", 32'(a_done), 32'(m_done));
      chk("done_b", 32'(b_done), 32'(m_done));
      if (a_done) begin
        if (qa.size() == 0) chk("sb_empty_a", 32'(0), 32'(1));
        else begin
          e = qa.pop_front();
          chk("v_a", 32'(a_v), 32'(e.v));
          chk("spike_a", 32'(a_spk), 32'(e.spk));
          chk("cnt_a", 32'(a_cnt), 32'(e.cnt));
        end
      end else chk("spike_idle_a", 32'(a_spk), 32'(0));
      if (b_done) begin
        if (qb.size() == 0) chk("sb_empty_b", 32'(0), 32'(1));
        else begin
          e = qb.pop_front();
          chk("v_b", 32'(b_v), 32'(e.v));
          chk("spike_b", 32'(b_spk), 32'(e.spk));
          chk("cnt_b", 32'(b_cnt), 32'(e.cnt));
        end
      end else chk("spike_idle_b", 32'(b_spk), 32'(0));
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_v_a"}, 32'(a_v), 32'h0000BA00);
    chk({tag, "_v_b"}, 32'(b_v), 32'h0000BA00);
    chk({tag, "_cnt_a"}, 32'(a_cnt), 32'(0));
    chk({tag, "_busy_a"}, 32'(a_busy), 32'(0));
    chk({tag, "_done_a"}, 32'(a_done), 32'(0));
    chk({tag, "_spike_a"}, 32'(a_spk), 32'(0));
    chk({tag, "_mul_en_a"}, 32'(ifa.mul_en), 32'(0));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_check("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic randomize_inputs();
    g_l   = 16'($urandom_range(0, 16'h7FFF));
    g_na  = 16'($urandom_range(0, 16'h7FFF));
    g_k   = 16'($urandom_range(0, 16'h7FFF));
    i_ext = 16'($urandom);
  endtask

  // One step; returns how many busy cycles had mul_en high.
  task automatic step(input bit scramble, output int n_en);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_en = int'(ifa.mul_en);
    if (scramble) randomize_inputs();
    repeat (3) begin
      @(posedge clk);
      #1 n_en += int'(ifa.mul_en);
      if (scramble) randomize_inputs();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    #12 rst_n = 1'b0;
    #1 reset_check("async");
    chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    g_l = '0; g_na = '0; g_k = '0; i_ext = 16'h7FFF;
    step(1'b0, n);
    chk("sat1_v_b", 32'(b_v), 32'h000039FF);
    chk("sat1_spike_b", 32'(b_spk), 32'(1));
    step(1'b0, n);
    chk("sat2_v_b", 32'(b_v), 32'h00007FFF);
    chk("sat2_spike_b", 32'(b_spk), 32'(0));

    do_reset();
    g_l = 16'h0100; g_na = '0; g_k = '0; i_ext = '0;
    step(1'b0, n);
    chk("eq_mul_en_cycles", 32'(n), 32'(3));
    chk("eq_done", 32'(a_done), 32'(1));
    chk("eq_v_a", 32'(a_v), 32'h0000BA00);
    chk("eq_cnt_a", 32'(a_cnt), 32'(1));

    i_ext = 16'h1000;
    step(1'b1, n);
    chk("inj_v_a", 32'(a_v), 32'h0000BB00);
    chk("inj_spike_a", 32'(a_spk), 32'(0));

    repeat (4) step(1'b1, n);

    @(posedge clk);
    #1 start = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1 randomize_inputs();
    end
    start = 1'b0;
    repeat (6) @(posedge clk);

    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 reset_check("mid");
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("mid_cnt_hold", 32'(a_cnt), 32'(0));
    g_l = 16'h0100; g_na = '0; g_k = '0; i_ext = 16'h1000;
    step(1'b0, n);
    chk("mid_resume_v_a", 32'(a_v), 32'h0000BB00);
    chk("mid_resume_cnt_a", 32'(a_cnt), 32'(1));

    repeat (3) @(posedge clk);
    chk("sb_drained_a", 32'(qa.size()), 32'(0));
    chk("sb_drained_b", 32'(qb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
